switch_bounce_gen: RTL and testbench

Synthesizable contact-bounce emulator: converts a clean level command into a switch-like waveform. The waveform chatters for a programmed bounce window, then settles on the commanded level. The output drives the switch input of the debouncer during on-FPGA self-test and board bring-up. It replaces the physical push-button, so debounce timing is checked with repeatable, seedable bounce patterns.

---
 rtl/switch_bounce_gen.sv | 138 +++++++++++++
 tb/tb_switch_bounce_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_bounce_gen.sv
// Contact-bounce emulator: turns a clean level command into a switch-like waveform
// that chatters with LFSR-sized segments for a fixed window, then settles on the target.
module switch_bounce_gen #(
  parameter int unsigned ClkFreq    = 100_000_000,
  parameter int unsigned BounceTime = 10,
  parameter int unsigned MinSeg     = 4,
  parameter int unsigned SegBits    = 8,
  parameter logic [15:0] Seed       = 16'hACE1,
  parameter logic        InitLevel  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  input  logic       cmd_level_i,
  output logic       cmd_ready_o,
  output logic       sw_o,
  output logic       busy_o,
  output logic       done_tick_o,
  output logic [7:0] edges_o
);

  localparam longint unsigned CycleProd = 64'(ClkFreq) * 64'(BounceTime);
  localparam int unsigned BounceCycles  = 32'(CycleProd / 64'd1_000_000);
  // A zero-length window never enters BOUNCE; keep the counter at least one bit wide.
  localparam int unsigned WinW = (BounceCycles == 0) ? 1 : $clog2(BounceCycles + 1);
  localparam int unsigned SegW = $clog2(MinSeg + (1 << SegBits));
  localparam logic [WinW-1:0] WinLast = (BounceCycles == 0) ? '0 : WinW'(BounceCycles - 1);
  localparam logic [15:0] SegMask = 16'((32'd1 << SegBits) - 32'd1);
  localparam logic [15:0] SeedEff = (Seed == 16'h0000) ? 16'hACE1 : Seed;

  typedef enum logic {StIdle, StBounce} state_e;

  state_e          r_state, w_state_next;
  logic            r_sw, w_sw_next;
  logic            r_target, w_target_next;
  logic [WinW-1:0] r_win, w_win_next;
  logic [SegW-1:0] r_seg, w_seg_next;
  logic [15:0]     r_lfsr, w_lfsr_next;
  logic            r_done, w_done_next;
  logic [7:0]      r_edges, w_edges_next;

  logic            w_accept;
  logic [SegW-1:0] w_seg_len;

  // Galois form, taps x^16+x^14+x^13+x^11+1; a nonzero state never reaches zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  assign w_accept  = cmd_valid_i && (r_state == StIdle);
  assign w_seg_len = SegW'(MinSeg) + SegW'(r_lfsr & SegMask);

  always_comb begin
    w_state_next  = r_state;
    w_sw_next     = r_sw;
    w_target_next = r_target;
    w_win_next    = r_win;
    w_seg_next    = r_seg;
    w_lfsr_next   = r_lfsr;
    w_done_next   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_level_i == r_sw) begin
            w_done_next = 1'b1;
          end else if (BounceCycles == 0) begin
            w_sw_next   = cmd_level_i;
            w_done_next = 1'b1;
          end else begin
            w_state_next  = StBounce;
            w_target_next = cmd_level_i;
            w_sw_next     = ~r_sw;
            w_win_next    = '0;
            w_seg_next    = w_seg_len;
            w_lfsr_next   = lfsr_step(r_lfsr);
          end
        end
      end
      StBounce: begin
        // Window end wins over a coinciding segment expiry.
        if (r_win == WinLast) begin
          w_state_next = StIdle;
          w_sw_next    = r_target;
          w_done_next  = 1'b1;
          w_win_next   = '0;
          w_seg_next   = '0;
        end else begin
          w_win_next = r_win + WinW'(1);
          if (r_seg == SegW'(1)) begin
            w_sw_next   = ~r_sw;
            w_seg_next  = w_seg_len;
            w_lfsr_next = lfsr_step(r_lfsr);
          end else begin
            w_seg_next = r_seg - SegW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    w_edges_next = r_edges;
    if (w_accept) begin
      w_edges_next = (w_sw_next != r_sw) ? 8'd1 : 8'd0;
    end else if ((w_sw_next != r_sw) && (r_edges != 8'hFF)) begin
      w_edges_next = r_edges + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_sw     <= InitLevel;
      r_target <= InitLevel;
      r_win    <= '0;
      r_seg    <= '0;
      r_lfsr   <= SeedEff;
      r_done   <= 1'b0;
      r_edges  <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_sw     <= w_sw_next;
      r_target <= w_target_next;
      r_win    <= w_win_next;
      r_seg    <= w_seg_next;
      r_lfsr   <= w_lfsr_next;
      r_done   <= w_done_next;
      r_edges  <= w_edges_next;
    end
  end

  assign cmd_ready_o = (r_state == StIdle);
  assign busy_o      = (r_state == StBounce);
  assign sw_o        = r_sw;
  assign done_tick_o = r_done;
  assign edges_o     = r_edges;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench for switch_bounce_gen: fixed, no-op, busy, abort, clean and LFSR-driven runs.
module tb_switch_bounce_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lvl = 1'b0;
  logic fv = 1'b0, cv = 1'b0, rv = 1'b0, zv = 1'b0;

  logic       fx_rdy, fx_sw, fx_busy, fx_done;
  logic [7:0] fx_edges;
  logic       cl_rdy, cl_sw, cl_busy, cl_done;
  logic [7:0] cl_edges;
  logic       rn_rdy, rn_sw, rn_busy, rn_done;
  logic [7:0] rn_edges;
  logic       sz_rdy, sz_sw, sz_busy, sz_done;
  logic [7:0] sz_edges;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  switch_bounce_gen #(.ClkFreq(1_000_000), .BounceTime(20), .MinSeg(3), .SegBits(0),
                      .Seed(16'hACE1), .InitLevel(1'b0)) u_fix (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(fv), .cmd_level_i(lvl), .cmd_ready_o(fx_rdy),
    .sw_o(fx_sw), .busy_o(fx_busy), .done_tick_o(fx_done), .edges_o(fx_edges));

  switch_bounce_gen #(.ClkFreq(1_000_000), .BounceTime(0), .MinSeg(3), .SegBits(0),
                      .Seed(16'hACE1), .InitLevel(1'b1)) u_cln (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cv), .cmd_level_i(lvl), .cmd_ready_o(cl_rdy),
    .sw_o(cl_sw), .busy_o(cl_busy), .done_tick_o(cl_done), .edges_o(cl_edges));

  switch_bounce_gen #(.ClkFreq(1_000_000), .BounceTime(40), .MinSeg(2), .SegBits(4),
                      .Seed(16'h0001), .InitLevel(1'b0)) u_rnd (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(rv), .cmd_level_i(lvl), .cmd_ready_o(rn_rdy),
    .sw_o(rn_sw), .busy_o(rn_busy), .done_tick_o(rn_done), .edges_o(rn_edges));

  switch_bounce_gen #(.ClkFreq(1_000_000), .BounceTime(40), .MinSeg(2), .SegBits(4),
                      .Seed(16'h0000), .InitLevel(1'b0)) u_sz (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(zv), .cmd_level_i(lvl), .cmd_ready_o(sz_rdy),
    .sw_o(sz_sw), .busy_o(sz_busy), .done_tick_o(sz_done), .edges_o(sz_edges));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Expected sw trace for a 0->1 command with a 40-cycle window, MinSeg 2, SegBits 4.
  // Bit k is the level seen k cycles after the accepting edge.
  function automatic logic [63:0] model_trace(input logic [15:0] seed);
    logic [63:0] tr;
    logic [15:0] lf;
    logic        s;
    int          seg;
    tr = '0;
    s = 1'b0;
    lf = seed;
    tr[0] = s;
    s = ~s;
    seg = 2 + int'(lf & 16'h000F);
    lf = lfsr_step(lf);
    tr[1] = s;
    for (int k = 2; k <= 40; k++) begin
      if (seg == 1) begin
        s = ~s;
        seg = 2 + int'(lf & 16'h000F);
        lf = lfsr_step(lf);
      end else begin
        seg--;
      end
      tr[k] = s;
    end
    tr[41] = 1'b1;
    return tr;
  endfunction

  function automatic int count_edges(input logic [63:0] tr);
    int n;
    n = 0;
    for (int k = 1; k <= 41; k++) if (tr[k] != tr[k-1]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    n_chk++; if (cl_sw !== 1'b1) $display("FAIL reset_sw: got %b expected 1", cl_sw);
    else n_pass++;
    n_chk++; if (cl_rdy !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cl_rdy);
    else n_pass++;
    n_chk++; if (cl_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", cl_busy);
    else n_pass++;
    n_chk++; if (cl_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", cl_done);
    else n_pass++;
    n_chk++; if (cl_edges !== 8'd0) $display("FAIL reset_edges: got %0d expected 0", cl_edges);
    else n_pass++;
    n_chk++; if (fx_sw !== 1'b0) $display("FAIL reset_fix_sw: got %b expected 0", fx_sw);
    else n_pass++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_noop();
    lvl = 1'b0;
    fv = 1'b1;
    cyc();
    fv = 1'b0;
    n_chk++; if (fx_sw !== 1'b0) $display("FAIL noop_sw: got %b expected 0", fx_sw);
    else n_pass++;
    n_chk++; if (fx_done !== 1'b1) $display("FAIL noop_done: got %b expected 1", fx_done);
    else n_pass++;
    n_chk++; if (fx_edges !== 8'd0) $display("FAIL noop_edges: got %0d expected 0", fx_edges);
    else n_pass++;
    n_chk++; if (fx_busy !== 1'b0) $display("FAIL noop_busy: got %b expected 0", fx_busy);
    else n_pass++;
    cyc();
    n_chk++; if (fx_done !== 1'b0) $display("FAIL noop_done_end: got %b expected 0", fx_done);
    else n_pass++;
    n_chk++; if (fx_busy !== 1'b0) $display("FAIL noop_busy_end: got %b expected 0", fx_busy);
    else n_pass++;
  endtask

  // Toggles at 1,4,...,19 (seven of them), forced target at 21.
  task automatic test_fixed();
    logic e_sw, e_busy, e_done;
    lvl = 1'b1;
    fv = 1'b1;
    cyc();
    fv = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      e_sw = 1'(((k >= 19) ? 7 : ((k - 1) / 3 + 1)) & 1);
      e_busy = (k <= 20);
      e_done = (k == 21);
      n_chk++; if (fx_sw !== e_sw) $display("FAIL fixed_sw k=%0d: got %b expected %b", k, fx_sw, e_sw);
      else n_pass++;
      n_chk++;
      if (fx_busy !== e_busy) $display("FAIL fixed_busy k=%0d: got %b expected %b", k, fx_busy, e_busy);
      else n_pass++;
      n_chk++;
      if (fx_done !== e_done) $display("FAIL fixed_done k=%0d: got %b expected %b", k, fx_done, e_done);
      else n_pass++;
      if (k == 21) begin
        n_chk++; if (fx_edges !== 8'd7) $display("FAIL fixed_edges: got %0d expected 7", fx_edges);
        else n_pass++;
        n_chk++; if (fx_rdy !== 1'b1) $display("FAIL fixed_ready: got %b expected 1", fx_rdy);
        else n_pass++;
      end
      cyc();
    end
  endtask

  // Valid held high through BOUNCE; the only second accept is a no-op on the done cycle.
  task automatic test_busy();
    logic e_sw, e_rdy, e_done;
    lvl = 1'b0;
    fv = 1'b1;
    cyc();
    for (int k = 1; k <= 22; k++) begin
      e_sw = ~1'(((k >= 19) ? 7 : ((k - 1) / 3 + 1)) & 1);
      e_rdy = (k >= 21);
      e_done = (k >= 21);
      n_chk++; if (fx_sw !== e_sw) $display("FAIL busy_sw k=%0d: got %b expected %b", k, fx_sw, e_sw);
      else n_pass++;
      n_chk++;
      if (fx_rdy !== e_rdy) $display("FAIL busy_ready k=%0d: got %b expected %b", k, fx_rdy, e_rdy);
      else n_pass++;
      n_chk++;
      if (fx_done !== e_done) $display("FAIL busy_done k=%0d: got %b expected %b", k, fx_done, e_done);
      else n_pass++;
      if (k == 21) begin
        n_chk++; if (fx_edges !== 8'd7) $display("FAIL busy_edges: got %0d expected 7", fx_edges);
        else n_pass++;
      end
      if (k == 22) begin
        n_chk++; if (fx_edges !== 8'd0) $display("FAIL busy_noop_edges: got %0d expected 0", fx_edges);
        else n_pass++;
        fv = 1'b0;
      end
      cyc();
    end
    n_chk++; if (fx_done !== 1'b0) $display("FAIL busy_done_end: got %b expected 0", fx_done);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic seen;
    lvl = 1'b1;
    fv = 1'b1;
    cyc();
    fv = 1'b0;
    repeat (7) cyc();
    n_chk++; if (fx_sw !== 1'b1) $display("FAIL abort_pre_sw: got %b expected 1", fx_sw);
    else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_chk++; if (fx_sw !== 1'b0) $display("FAIL abort_sw: got %b expected 0", fx_sw);
    else n_pass++;
    n_chk++; if (fx_busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", fx_busy);
    else n_pass++;
    n_chk++; if (fx_rdy !== 1'b1) $display("FAIL abort_ready: got %b expected 1", fx_rdy);
    else n_pass++;
    n_chk++; if (fx_edges !== 8'd0) $display("FAIL abort_edges: got %0d expected 0", fx_edges);
    else n_pass++;
    seen = fx_done;
    for (int k = 0; k < 25; k++) begin
      if (fx_done === 1'b1 || fx_busy === 1'b1) seen = 1'b1;
      cyc();
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", seen);
    else n_pass++;
  endtask

  task automatic test_clean();
    lvl = 1'b0;
    cv = 1'b1;
    cyc();
    cv = 1'b0;
    n_chk++; if (cl_sw !== 1'b0) $display("FAIL clean_fall_sw: got %b expected 0", cl_sw);
    else n_pass++;
    n_chk++; if (cl_done !== 1'b1) $display("FAIL clean_fall_done: got %b expected 1", cl_done);
    else n_pass++;
    n_chk++; if (cl_edges !== 8'd1) $display("FAIL clean_fall_edges: got %0d expected 1", cl_edges);
    else n_pass++;
    n_chk++; if (cl_busy !== 1'b0) $display("FAIL clean_busy: got %b expected 0", cl_busy);
    else n_pass++;
    cyc();
    n_chk++; if (cl_done !== 1'b0) $display("FAIL clean_done_end: got %b expected 0", cl_done);
    else n_pass++;
    lvl = 1'b1;
    cv = 1'b1;
    cyc();
    cv = 1'b0;
    n_chk++; if (cl_sw !== 1'b1) $display("FAIL clean_rise_sw: got %b expected 1", cl_sw);
    else n_pass++;
    n_chk++; if (cl_done !== 1'b1) $display("FAIL clean_rise_done: got %b expected 1", cl_done);
    else n_pass++;
    n_chk++; if (cl_edges !== 8'd1) $display("FAIL clean_rise_edges: got %0d expected 1", cl_edges);
    else n_pass++;
    cv = 1'b1;
    cyc();
    cv = 1'b0;
    n_chk++; if (cl_edges !== 8'd0) $display("FAIL clean_noop_edges: got %0d expected 0", cl_edges);
    else n_pass++;
    n_chk++; if (cl_done !== 1'b1) $display("FAIL clean_noop_done: got %b expected 1", cl_done);
    else n_pass++;
  endtask

  task automatic test_random(input logic use_sz, input logic [15:0] mseed, input string tag);
    logic [63:0] tr;
    logic        prev, cur, dn;
    logic [7:0]  ed;
    int          last_t;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    lvl = 1'b1;
    if (use_sz) zv = 1'b1;
    else rv = 1'b1;
    cyc();
    zv = 1'b0;
    rv = 1'b0;
    tr = model_trace(mseed);
    prev = 1'b0;
    last_t = 0;
    for (int k = 1; k <= 41; k++) begin
      cur = use_sz ? sz_sw : rn_sw;
      n_chk++;
      if (cur !== tr[k]) $display("FAIL %s_trace k=%0d: got %b expected %b", tag, k, cur, tr[k]);
      else n_pass++;
      if (k <= 40 && cur !== prev) begin
        if (last_t > 0) begin
          n_chk++;
          if ((k - last_t) < 2 || (k - last_t) > 17)
            $display("FAIL %s_seg_len k=%0d: got %0d expected 2..17", tag, k, k - last_t);
          else n_pass++;
        end
        last_t = k;
      end
      prev = cur;
      if (k == 41) begin
        dn = use_sz ? sz_done : rn_done;
        ed = use_sz ? sz_edges : rn_edges;
        n_chk++; if (dn !== 1'b1) $display("FAIL %s_done: got %b expected 1", tag, dn);
        else n_pass++;
        n_chk++;
        if (ed !== 8'(count_edges(tr)))
          $display("FAIL %s_edges: got %0d expected %0d", tag, ed, count_edges(tr));
        else n_pass++;
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_noop();
    test_fixed();
    test_busy();
    test_abort();
    test_clean();
    test_random(1'b0, 16'h0001, "rand_run1");
    test_random(1'b0, 16'h0001, "rand_run2");
    test_random(1'b1, 16'hACE1, "seed_zero");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
